// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: opcodes, function codes,
// ALU operation encoding and the immediate sign-extension helper.
package mips_pkg;

  localparam int NREGS = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLT
  } alu_op_e;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/single_cycle_mips_core_if.sv
// Memory-side bus of the core: instruction ROM fetch and data RAM access.
// The core is the master; the memory system (ROM + RAM) is the slave.
interface single_cycle_mips_core_if;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic [31:0] data_addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_wr;

  modport master (
    output inst_addr, data_addr, data_in, data_wr,
    input  inst, data_out
  );

  modport slave (
    input  inst_addr, data_addr, data_in, data_wr,
    output inst, data_out
  );
endinterface

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one write port on the
// rising clock edge, asynchronous clear, and $0 hardwired to zero.
module mips_regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [NREGS];

  // Clear every register on reset; otherwise write one register, never $0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs[raddr_b];

endmodule

// File: rtl/single_cycle_mips_core.sv
// Single-cycle MIPS subset core (lw, sw, add, sub, slt, beq, bne).
// Every instruction is fetched, decoded, executed and retired in one clock.
// Anything not recognised, including the all-zero word, behaves as a NOP.
module single_cycle_mips_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                        clk,
  input logic                        rst_n,
  single_cycle_mips_core_if.master   bus
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [31:0] inst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] imm_ext;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_result;
  logic [31:0] wb_data;
  logic [4:0]  reg_waddr;
  logic        reg_we;
  logic        mem_to_reg;
  logic        is_sw;
  logic        branch_take;
  alu_op_e     alu_op;

  assign inst    = bus.inst;
  assign opcode  = inst[31:26];
  assign rs      = inst[25:21];
  assign rt      = inst[20:16];
  assign rd      = inst[15:11];
  assign funct   = inst[5:0];
  assign imm_ext = sign_ext16(inst[15:0]);

  mips_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rs_val),
    .rdata_b (rt_val),
    .we      (reg_we),
    .waddr   (reg_waddr),
    .wdata   (wb_data)
  );

  // Decode the instruction into register-write, memory and branch controls.
  always_comb begin
    reg_we      = 1'b0;
    reg_waddr   = rd;
    mem_to_reg  = 1'b0;
    is_sw       = 1'b0;
    branch_take = 1'b0;
    alu_op      = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin reg_we = 1'b1; alu_op = ALU_ADD; end
          FN_SUB: begin reg_we = 1'b1; alu_op = ALU_SUB; end
          FN_SLT: begin reg_we = 1'b1; alu_op = ALU_SLT; end
          default: ;
        endcase
      end
      OP_LW: begin
        reg_we     = 1'b1;
        reg_waddr  = rt;
        mem_to_reg = 1'b1;
      end
      OP_SW:   is_sw = 1'b1;
      OP_BEQ:  branch_take = (rs_val == rt_val);
      OP_BNE:  branch_take = (rs_val != rt_val);
      default: ;
    endcase
  end

  // Register-register ALU; slt compares as signed and yields 0 or 1.
  always_comb begin
    alu_result = rs_val + rt_val;
    case (alu_op)
      ALU_ADD: alu_result = rs_val + rt_val;
      ALU_SUB: alu_result = rs_val - rt_val;
      ALU_SLT: alu_result = {31'd0, ($signed(rs_val) < $signed(rt_val))};
      default: alu_result = rs_val + rt_val;
    endcase
  end

  assign wb_data  = mem_to_reg ? bus.data_out : alu_result;
  assign pc_plus4 = pc + 32'd4;
  assign pc_next  = branch_take ? (pc_plus4 + {imm_ext[29:0], 2'b00}) : pc_plus4;

  // Program counter: async return to RESET_PC, otherwise advance every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  assign bus.inst_addr = pc;
  assign bus.data_addr = rs_val + imm_ext;
  assign bus.data_in   = rt_val;
  assign bus.data_wr   = is_sw & rst_n;

endmodule

// File: tb/tb_single_cycle_mips_core.sv
// Self-checking bench for single_cycle_mips_core: ROM/RAM models, directed
// program, store scoreboard and final data-memory comparison.
module tb_single_cycle_mips_core;
  import mips_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } store_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] rom [64];
  logic [7:0]  mem [256];
  logic [31:0] golden [22];
  store_t      exp_q [$];
  logic [7:0]  ra;

  single_cycle_mips_core_if bus();

  single_cycle_mips_core #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.inst     = rom[bus.inst_addr[7:2]];
  assign ra           = bus.data_addr[7:0];
  assign bus.data_out = {mem[ra], mem[ra + 8'd1], mem[ra + 8'd2], mem[ra + 8'd3]};

  // Big-endian data RAM write on the rising edge.
  always @(posedge clk) begin
    if (bus.data_wr) begin
      mem[ra]        <= bus.data_in[31:24];
      mem[ra + 8'd1] <= bus.data_in[23:16];
      mem[ra + 8'd2] <= bus.data_in[15:8];
      mem[ra + 8'd3] <= bus.data_in[7:0];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    return {OP_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs,
                                        input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] init_word(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  function automatic logic [31:0] rd_word(input int a);
    return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
  endfunction

  task automatic push_store(input logic [31:0] a, input logic [31:0] d);
    store_t s;
    s.addr = a;
    s.data = d;
    exp_q.push_back(s);
  endtask

  // Scoreboard: every store seen on the bus must match the next expected one.
  always @(negedge clk) begin
    if (rst_n && bus.data_wr) begin
      checkOutput("store_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        store_t s;
        s = exp_q.pop_front();
        checkOutput("store_addr", bus.data_addr, s.addr);
        checkOutput("store_data", bus.data_in, s.data);
      end
    end
  end

  task automatic applyStimulus();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    for (int a = 0; a < 256; a += 4) begin
      logic [31:0] w;
      w = init_word(a);
      {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]} = w;
    end
    {mem[0], mem[1], mem[2], mem[3]} = 32'h0000_0005;
    {mem[4], mem[5], mem[6], mem[7]} = 32'h0000_0003;

    rom[0]  = enc_i(OP_LW, 0, 1, 0);
    rom[1]  = enc_i(OP_LW, 0, 2, 4);
    rom[2]  = enc_i(OP_SW, 0, 1, 12);
    rom[3]  = enc_r(1, 2, 3, FN_ADD);
    rom[4]  = enc_r(1, 2, 4, FN_SUB);
    rom[5]  = enc_r(2, 1, 5, FN_SLT);
    rom[6]  = enc_r(1, 2, 6, FN_SLT);
    rom[7]  = enc_i(OP_SW, 0, 3, 16);
    rom[8]  = enc_i(OP_SW, 0, 4, 20);
    rom[9]  = enc_i(OP_SW, 0, 5, 24);
    rom[10] = enc_i(OP_SW, 0, 6, 28);
    rom[11] = enc_r(2, 1, 7, FN_SUB);
    rom[12] = enc_i(OP_SW, 0, 7, 32);
    rom[13] = enc_i(OP_BEQ, 1, 1, 1);
    rom[14] = enc_i(OP_SW, 0, 1, 36);
    rom[15] = enc_i(OP_BEQ, 1, 2, 1);
    rom[16] = enc_i(OP_SW, 0, 1, 40);
    rom[17] = enc_i(OP_BNE, 1, 2, 1);
    rom[18] = enc_i(OP_SW, 0, 1, 44);
    rom[19] = enc_i(OP_BNE, 1, 1, 1);
    rom[20] = enc_i(OP_SW, 0, 2, 48);
    rom[21] = enc_r(1, 2, 0, FN_ADD);
    rom[22] = enc_i(OP_SW, 0, 0, 52);
    rom[23] = enc_i(6'h3F, 1, 8, 16'h1234);
    rom[24] = enc_i(OP_SW, 0, 8, 56);
    rom[25] = enc_r(3, 3, 10, FN_ADD);
    rom[26] = enc_i(OP_LW, 10, 11, -12);
    rom[27] = enc_i(OP_SW, 0, 11, 60);

    push_store(32'd12, 32'h0000_0005);
    push_store(32'd16, 32'h0000_0008);
    push_store(32'd20, 32'h0000_0002);
    push_store(32'd24, 32'h0000_0001);
    push_store(32'd28, 32'h0000_0000);
    push_store(32'd32, 32'hFFFF_FFFE);
    push_store(32'd40, 32'h0000_0005);
    push_store(32'd48, 32'h0000_0003);
    push_store(32'd52, 32'h0000_0000);
    push_store(32'd56, 32'h0000_0000);
    push_store(32'd60, 32'h0000_0003);

    for (int i = 0; i < 22; i++) golden[i] = init_word(i * 4);
    golden[3]  = 32'h0000_0005;
    golden[4]  = 32'h0000_0008;
    golden[5]  = 32'h0000_0002;
    golden[6]  = 32'h0000_0001;
    golden[7]  = 32'h0000_0000;
    golden[8]  = 32'hFFFF_FFFE;
    golden[10] = 32'h0000_0005;
    golden[12] = 32'h0000_0003;
    golden[13] = 32'h0000_0000;
    golden[14] = 32'h0000_0000;
    golden[15] = 32'h0000_0003;
  endtask

  initial begin
    int zeros;
    int cyc;
    $display("[TB] start");
    rst_n = 1'b0;
    applyStimulus();

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("reset_inst_addr", bus.inst_addr, 32'h0);
      checkOutput("reset_data_wr", 32'(bus.data_wr), 32'h0);
    end

    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 checkOutput("release_pc0", bus.inst_addr, 32'h0);
    @(negedge clk);
    checkOutput("first_fetch", bus.inst_addr, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("fetch_seq_%0d", k), bus.inst_addr, 32'(4 * k));
    end

    zeros = 0;
    cyc = 0;
    while (zeros < 9 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      zeros = (bus.inst == 32'h0) ? zeros + 1 : 0;
    end
    checkOutput("watchdog", 32'(zeros >= 9), 32'd1);
    checkOutput("stores_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 3; i <= 21; i++) begin
      checkOutput($sformatf("dmem_word_%0d", i), rd_word(i * 4), golden[i]);
    end

    @(negedge clk);
    rst_n = 1'b0;
    push_store(32'd12, 32'h0000_0005);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rerun_pc", bus.inst_addr, 32'd8);
    checkOutput("rerun_sw_wr", 32'(bus.data_wr), 32'd1);
    #2 rst_n = 1'b0;
    #1 checkOutput("midrun_reset_pc", bus.inst_addr, 32'h0);
    checkOutput("midrun_reset_wr", 32'(bus.data_wr), 32'h0);

    rom[0] = enc_i(OP_SW, 0, 1, 100);
    push_store(32'd100, 32'h0000_0000);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("regs_cleared_mem", rd_word(100), 32'h0000_0000);
    checkOutput("stores_drained_end", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
